// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared types and constants for the ALU sequencer: FSM states,
//          ALU function encoding, instruction class and flag bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // Sequencer phases, in the order an ALU instruction walks through them
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_ENABLE  = 3'd2,
    ST_LATCH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Function codes as seen by the 3-to-8 decoder (the fff field)
  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_INC = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_NOT = 3'b101,
    FN_SHL = 3'b110,
    FN_CLR = 3'b111
  } fn_t;

  // Upper nibble that marks an ALU-class instruction byte
  localparam logic [3:0] ALU_CLASS = 4'b1000;

  // Bit positions inside the {S,C,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;

  // Only ADD and INC produce a meaningful carry; other functions clear C
  function automatic logic fn_keeps_carry(input logic [2:0] fn);
    return (fn == FN_ADD) || (fn == FN_INC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_settle_counter.sv
// ============================================================================
// Module : settle_counter
// Brief  : 4-bit down-counter with synchronous load, decrement and a zero
//          flag. Times how long the decoder enable dwells while the relay
//          contacts settle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module settle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] r_count;

  // Load takes priority; decrement stops at zero so the flag stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Drives the ALU function decoder in relay-safe order (code, then
//          enable, then release), samples the ALU result, strobes the A or D
//          load and updates the {S,C,Z} flags.
//          Optional macro RELAY_SETTLE_EN: enable dwells SETTLE_CYCLES cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [2:0] fctn_code,
  output logic       v_en,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       ld_a,
  output logic       ld_d,
  output logic [7:0] data_out,
  output logic [2:0] flags,
  output logic       done,
  output logic       illegal
);

  // A dwell outside 1..15 cannot be represented by the 4-bit settle counter
  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_settle_range_chk
    $error("alu_sequencer: SETTLE_CYCLES must be within 1..15");
  end

  state_t r_state;
  state_t w_next_state;
  logic   r_dst;          // 0 = A, 1 = D
  logic   w_accept;
  logic   w_is_alu;
  logic   w_settle_done;

  assign instr_ready = (r_state == ST_IDLE);
  assign w_accept    = instr_valid && instr_ready;
  assign w_is_alu    = (instr[7:4] == ALU_CLASS);

`ifdef RELAY_SETTLE_EN
  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);
  logic w_cnt_zero;

  // Loaded while DRIVE so ENABLE starts with SETTLE_CYCLES-1 cycles to go
  settle_counter u_settle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_DRIVE),
    .load_val (c_settle_load),
    .dec      (r_state == ST_ENABLE),
    .zero     (w_cnt_zero)
  );

  assign w_settle_done = w_cnt_zero;
`else
  // Without relay settling the enable phase is a single cycle
  assign w_settle_done = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && w_is_alu) w_next_state = ST_DRIVE;
      ST_DRIVE:   w_next_state = ST_ENABLE;
      ST_ENABLE:  if (w_settle_done) w_next_state = ST_LATCH;
      ST_LATCH:   w_next_state = ST_RELEASE;
      ST_RELEASE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Registered strobes and enable, decoded from the state being entered so
  // they line up with the state itself and drop glitch-free on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_en    <= 1'b0;
      ld_a    <= 1'b0;
      ld_d    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      v_en    <= (w_next_state == ST_ENABLE) || (w_next_state == ST_LATCH);
      ld_a    <= (w_next_state == ST_LATCH) && !r_dst;
      ld_d    <= (w_next_state == ST_LATCH) &&  r_dst;
      done    <= (w_next_state == ST_RELEASE);
      illegal <= w_accept && !w_is_alu;
    end
  end

  // Function code and destination captured at accept; the code is held
  // through IDLE so the decoder never sees a spurious transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fctn_code <= FN_ADD;
      r_dst     <= 1'b0;
    end else if (w_accept && w_is_alu) begin
      fctn_code <= instr[2:0];
      r_dst     <= instr[3];
    end
  end

  // Result and condition flags sampled at the end of LATCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      flags    <= 3'b000;
    end else if (r_state == ST_LATCH) begin
      data_out      <= alu_result;
      flags[FLAG_Z] <= (alu_result == 8'h00);
      flags[FLAG_S] <= alu_result[7];
      flags[FLAG_C] <= fn_keeps_carry(fctn_code) ? alu_carry : 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module : tb_alu_sequencer
// Brief  : Self-checking bench for alu_sequencer: directed cases plus random
//          legal/illegal instruction bytes against a timeline/flag model.
//          Honours RELAY_SETTLE_EN for the expected enable dwell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

`ifdef RELAY_SETTLE_EN
  localparam int DWELL = 4;
`else
  localparam int DWELL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [2:0] fctn_code;
  logic       v_en;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       ld_a;
  logic       ld_d;
  logic [7:0] data_out;
  logic [2:0] flags;
  logic       done;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural state the DUT should expose
  logic [2:0] m_fn;
  logic [7:0] m_data;
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .fctn_code   (fctn_code),
    .v_en        (v_en),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .ld_a        (ld_a),
    .ld_d        (ld_d),
    .data_out    (data_out),
    .flags       (flags),
    .done        (done),
    .illegal     (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected architectural effect of one completed ALU operation
  task automatic model_commit(input logic [7:0] ins, input logic [7:0] res, input logic c);
    m_data     = res;
    m_flags[0] = (res == 8'h00);
    m_flags[2] = res[7];
    m_flags[1] = (ins[2:0] == 3'd0 || ins[2:0] == 3'd1) ? c : 1'b0;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_fctn"}, fctn_code, m_fn);
    chk({tag, "_data"}, data_out,  m_data);
    chk({tag, "_flags"}, flags,    m_flags);
  endtask

  // Called at a negedge in IDLE; returns at a negedge with the DUT idle again
  task automatic do_op(input logic [7:0] ins, input logic [7:0] res, input logic c);
    chk("ready_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    alu_result  = $urandom;
    alu_carry   = $urandom;
    @(posedge clk);
    @(negedge clk);
    if (ins[7:4] != 4'b1000) begin
      chk("ill_pulse", illegal, 1);
      chk("ill_ready", instr_ready, 1);
      chk("ill_ven", v_en, 0);
      chk("ill_ld", {ld_a, ld_d, done}, 0);
      chk_arch("ill");
      instr_valid = 1'b0;
      @(negedge clk);
      chk("ill_clear", illegal, 0);
      chk("ill_ven2", v_en, 0);
    end else begin
      m_fn = ins[2:0];
      for (int t = 1; t <= 4 + DWELL; t++) begin
        if (t > 1) @(negedge clk);
        if (t == 3 + DWELL) model_commit(ins, res, c);
        chk("v_en",    v_en,        (t >= 2 && t <= 2 + DWELL));
        chk("ld_a",    ld_a,        (t == 2 + DWELL) && !ins[3]);
        chk("ld_d",    ld_d,        (t == 2 + DWELL) &&  ins[3]);
        chk("done",    done,        (t == 3 + DWELL));
        chk("ready",   instr_ready, (t == 4 + DWELL));
        chk("illegal", illegal,     0);
        chk_arch("op");
        // Busy-time offers must be ignored; ALU inputs are junk except
        // while the sampling edge at the end of LATCH is pending
        instr_valid = (t < 3 + DWELL) ? 1'($urandom_range(0, 1)) : 1'b0;
        instr       = $urandom;
        alu_result  = (t == 2 + DWELL) ? res : 8'($urandom);
        alu_carry   = (t == 2 + DWELL) ? c   : 1'($urandom);
      end
    end
  endtask

  task automatic reset_mid_op();
    instr_valid = 1'b1;
    instr       = 8'h81;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_ven", v_en, 1);
    chk("rst_pre_fctn", fctn_code, 3'b001);
    rst_n = 1'b0;
    #1;
    m_fn = 3'd0; m_data = 8'h00; m_flags = 3'b000;
    chk("rst_ven", v_en, 0);
    chk_arch("rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_strobes", {v_en, ld_a, ld_d, done, illegal}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_strobes", {v_en, ld_a, ld_d, done}, 0);
    chk("rst_after_ready", instr_ready, 1);
  endtask

  initial begin
    logic [7:0] ins;
    logic [7:0] res;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    alu_result  = 8'h00;
    alu_carry   = 1'b0;
    m_fn = 3'd0; m_data = 8'h00; m_flags = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", instr_ready, 1);
    chk("reset_strobes", {v_en, ld_a, ld_d, done, illegal}, 0);
    chk_arch("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h80, 8'h00, 1'b1);   // ADD to A, zero with carry -> flags 011
    chk("add_flags", flags, 3'b011);
    do_op(8'h8C, 8'h9A, 1'b1);   // XOR to D, sign set, carry masked
    chk("xor_flags", flags, 3'b100);
    chk("xor_data", data_out, 8'h9A);
    do_op(8'h41, 8'h00, 1'b0);   // illegal byte
    reset_mid_op();
    do_op(8'h81, 8'h01, 1'b0);   // same instruction accepted after reset
    do_op(8'h89, 8'h7F, 1'b1);   // back-to-back pair
    do_op(8'h8E, 8'hFE, 1'b1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ins = $urandom;
        if (ins[7:4] == 4'b1000) ins[7:4] = 4'b0000;
      end else begin
        ins = {4'b1000, 4'($urandom)};
      end
      res = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      do_op(ins, res, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
